// File: rtl/cache_nway_cfg.sv
// N-way set-associative write-through, no-write-allocate cache (one word per line) between
// the picorv32 native memory port and the memory module, with an uncached I/O window.
module cache_nway_cfg #(
   parameter int          WAYS          = 2,
   parameter int          SETS          = 64,
   parameter int          POLICY        = 1,
   parameter logic [31:0] UNCACHED_BASE = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        mem_valid_m,
   output logic        mem_instr_m,
   output logic [31:0] mem_addr_m,
   output logic [31:0] mem_wdata_m,
   output logic [3:0]  mem_wstrb_m,
   input  logic        mem_ready_m,
   input  logic [31:0] mem_rdata_m,
   input  logic        flush,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_W = 30 - IDX_W;
   localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WTHRU, BYPASS, RESP} state_t;
   state_t state, state_nx;

   logic [31:0]      addr_q, wdata_q, rdata_q;
   logic [3:0]       wstrb_q;
   logic             instr_q;
   logic [15:0]      lfsr;
   logic [SETS-1:0]  valid_q [WAYS];
   logic [WAY_W-1:0] age_q   [WAYS][SETS];
   logic [WAY_W-1:0] fifo_q  [SETS];
   logic [TAG_W-1:0] tag_mem [WAYS][SETS];
   logic [31:0]      data_mem[WAYS][SETS];

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             cached, is_read;
   logic             hit, inv_found;
   logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim;
   logic             rd_hit, rd_miss, wr_hit, fill_done, touch;
   logic [WAY_W-1:0] touch_way, touch_age;

   assign idx     = addr_q[2+IDX_W-1:2];
   assign tag     = addr_q[31:2+IDX_W];
   assign cached  = (addr_q < UNCACHED_BASE);
   assign is_read = (wstrb_q == 4'b0000);

   // Descending scan so the lowest-index match wins.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      lru_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[w][idx] && (tag_mem[w][idx] == tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[w][idx]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
         if (age_q[w][idx] == OLDEST) lru_way = WAY_W'(w);
      end
   end

   always_comb begin
      victim = '0;
      if (inv_found)        victim = inv_way;
      else if (POLICY == 0) victim = WAY_W'(int'(lfsr) % WAYS);
      else if (POLICY == 1) victim = lru_way;
      else                  victim = fifo_q[idx];
   end

   assign rd_hit    = (state == LOOKUP) && cached && is_read && hit;
   assign rd_miss   = (state == LOOKUP) && cached && is_read && !hit;
   assign wr_hit    = (state == LOOKUP) && cached && !is_read && hit;
   assign fill_done = (state == FILL) && mem_ready_m;
   assign touch     = rd_hit || wr_hit || fill_done;
   assign touch_way = fill_done ? victim : hit_way;
   // A filled way is treated as the oldest, so an invalid way with a stale age still ages the others.
   assign touch_age = fill_done ? OLDEST : age_q[hit_way][idx];

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (!flush && mem_valid) state_nx = LOOKUP;
         LOOKUP: begin
            if (!cached)       state_nx = BYPASS;
            else if (!is_read) state_nx = WTHRU;
            else if (hit)      state_nx = RESP;
            else               state_nx = FILL;
         end
         FILL, WTHRU, BYPASS: if (mem_ready_m) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         lfsr       <= 16'hACE1;
         hit_count  <= '0;
         miss_count <= '0;
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) age_q[w][s] <= '0;
         end
         for (int s = 0; s < SETS; s++) fifo_q[s] <= '0;
      end else begin
         state <= state_nx;
         lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (rd_hit)  hit_count  <= hit_count + 32'd1;
         if (rd_miss) miss_count <= miss_count + 32'd1;
         // Ages return to the reset pattern so refills from all-invalid rebuild a clean order.
         if (state == IDLE && flush) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[w] <= '0;
               for (int s = 0; s < SETS; s++) age_q[w][s] <= '0;
            end
         end
         if (fill_done) begin
            valid_q[victim][idx] <= 1'b1;
            fifo_q[idx]          <= WAY_W'((int'(fifo_q[idx]) + 1) % WAYS);
         end
         if (touch && POLICY == 1) begin
            for (int w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == touch_way)          age_q[w][idx] <= '0;
               else if (age_q[w][idx] < touch_age) age_q[w][idx] <= age_q[w][idx] + WAY_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && !flush && mem_valid) begin
         addr_q  <= mem_addr;
         wdata_q <= mem_wdata;
         wstrb_q <= mem_wstrb;
         instr_q <= mem_instr;
      end
      case (state)
         LOOKUP: if (rd_hit) rdata_q <= data_mem[hit_way][idx];
         FILL:   if (mem_ready_m) rdata_q <= mem_rdata_m;
         WTHRU:  if (mem_ready_m) rdata_q <= '0;
         BYPASS: if (mem_ready_m) rdata_q <= is_read ? mem_rdata_m : 32'h0;
         default: ;
      endcase
      if (wr_hit) begin
         for (int b = 0; b < 4; b++)
            if (wstrb_q[b]) data_mem[hit_way][idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
      if (fill_done) begin
         data_mem[victim][idx] <= mem_rdata_m;
         tag_mem[victim][idx]  <= tag;
      end
   end

   // Memory-side outputs decode from state so an async reset drops the request immediately.
   always_comb begin
      mem_valid_m = (state == FILL) || (state == WTHRU) || (state == BYPASS);
      mem_addr_m  = mem_valid_m ? {addr_q[31:2], 2'b00} : 32'h0;
      mem_instr_m = mem_valid_m ? instr_q : 1'b0;
      mem_wdata_m = (mem_valid_m && state != FILL) ? wdata_q : 32'h0;
      mem_wstrb_m = (mem_valid_m && state != FILL) ? wstrb_q : 4'b0000;
      mem_ready   = (state == RESP);
      mem_rdata   = (state == RESP) ? rdata_q : 32'h0;
   end
endmodule

// File: tb/tb_cache_nway_cfg.sv
// Directed bench for cache_nway_cfg (2-way, 64 sets, LRU) with a 2-cycle memory model
// and a scoreboard queue of expected read data.
module tb_cache_nway_cfg;
   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid, mem_instr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_valid_m, mem_instr_m;
   logic [31:0] mem_addr_m, mem_wdata_m;
   logic [3:0]  mem_wstrb_m;
   logic        mem_ready_m;
   logic [31:0] mem_rdata_m;
   logic        flush;
   logic [31:0] hit_count, miss_count;

   always #5 clk = ~clk;

   cache_nway_cfg #(.WAYS(2), .SETS(64), .POLICY(1), .UNCACHED_BASE(32'h1000_0000)) dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .mem_valid_m(mem_valid_m), .mem_instr_m(mem_instr_m), .mem_addr_m(mem_addr_m),
      .mem_wdata_m(mem_wdata_m), .mem_wstrb_m(mem_wstrb_m), .mem_ready_m(mem_ready_m),
      .mem_rdata_m(mem_rdata_m), .flush(flush), .hit_count(hit_count), .miss_count(miss_count)
   );

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mem_arr [logic [31:0]];
   int          mem_reads = 0;
   int          mem_writes = 0;
   logic [3:0]  last_wstrb = 4'h0;
   logic [31:0] last_addr = 32'h0;
   bit          mem_hold = 1'b0;
   bit          flush_on_fill = 1'b0;
   int          wait_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory model: completes a request after it has been valid for 2 sampled cycles.
   initial begin
      logic [31:0] key, word;
      mem_ready_m = 1'b0;
      mem_rdata_m = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            wait_cnt    = 0;
            mem_ready_m = 1'b0;
         end else if (mem_ready_m) begin
            mem_ready_m = 1'b0;
            mem_rdata_m = 32'h0;
            wait_cnt    = 0;
         end else if (mem_valid_m && !mem_hold) begin
            if (flush_on_fill) flush = 1'b1;
            wait_cnt++;
            if (wait_cnt >= 2) begin
               key  = {mem_addr_m[31:2], 2'b00};
               word = mem_arr.exists(key) ? mem_arr[key] : 32'h0;
               if (mem_wstrb_m == 4'b0000) begin
                  mem_rdata_m = word;
                  mem_reads++;
               end else begin
                  for (int b = 0; b < 4; b++)
                     if (mem_wstrb_m[b]) word[8*b +: 8] = mem_wdata_m[8*b +: 8];
                  mem_arr[key] = word;
                  mem_writes++;
                  last_wstrb  = mem_wstrb_m;
                  last_addr   = mem_addr_m;
                  mem_rdata_m = 32'h0;
               end
               mem_ready_m = 1'b1;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // lat counts the cycle the request is presented as cycle 1.
   task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] exp,
                         output int lat, output int mvm);
      @(negedge clk);
      exp_q.push_back(exp);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      mem_instr = 1'b0;
      lat = 1;
      mvm = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (mem_valid_m) mvm++;
         if (mem_ready) break;
      end
      check({tag, "_ready"}, {31'b0, mem_ready}, 32'd1);
      check({tag, "_rdata"}, mem_rdata, exp_q.pop_front());
      mem_valid = 1'b0;
      mem_wstrb = 4'b0000;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat, mvm, r0, w0;
      reset = 1'b1; flush = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
      mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
      mem_arr[32'h100] = 32'hDEADBEEF;
      mem_arr[32'h004] = 32'hA0A0_0004;
      mem_arr[32'h104] = 32'hB0B0_0104;
      mem_arr[32'h204] = 32'hC0C0_0204;
      mem_arr[32'h008] = 32'hAAAA_AAAA;
      for (int i = 0; i < 5; i++) mem_arr[32'h010 + 4*i] = 32'h5000_0000 + i;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_m", {31'b0, mem_valid_m}, 32'd0);
      check("rst_ready", {31'b0, mem_ready}, 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
      check("rst_hits", hit_count, 32'd0);
      check("rst_misses", miss_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Miss then hit on 0x100
      r0 = mem_reads;
      do_req("t1_rd1", 32'h100, 0, 4'h0, 32'hDEADBEEF, lat, mvm);
      check("t1_memrd", 32'(mem_reads - r0), 32'd1);
      check("t1_miss1", miss_count, 32'd1);
      check("t1_hit1", hit_count, 32'd0);
      do_req("t1_rd2", 32'h100, 0, 4'h0, 32'hDEADBEEF, lat, mvm);
      check("t1_hit_lat", 32'(lat), 32'd3);
      check("t1_no_mvm", 32'(mvm), 32'd0);
      check("t1_hit2", hit_count, 32'd1);
      check("t1_miss2", miss_count, 32'd1);

      // LRU in set 1: A, B, A, C evicts B
      r0 = mem_reads;
      do_req("t2_a", 32'h004, 0, 4'h0, 32'hA0A0_0004, lat, mvm);
      do_req("t2_b", 32'h104, 0, 4'h0, 32'hB0B0_0104, lat, mvm);
      do_req("t2_a2", 32'h004, 0, 4'h0, 32'hA0A0_0004, lat, mvm);
      check("t2_a2_hit", 32'(mvm), 32'd0);
      do_req("t2_c", 32'h204, 0, 4'h0, 32'hC0C0_0204, lat, mvm);
      do_req("t2_a3", 32'h004, 0, 4'h0, 32'hA0A0_0004, lat, mvm);
      check("t2_a3_hit", 32'(mvm), 32'd0);
      do_req("t2_b2", 32'h104, 0, 4'h0, 32'hB0B0_0104, lat, mvm);
      check("t2_b2_miss", 32'(mvm > 0), 32'd1);
      check("t2_memrd", 32'(mem_reads - r0), 32'd4);
      check("t2_hits", hit_count, 32'd3);
      check("t2_misses", miss_count, 32'd5);

      // Partial write hit
      do_req("t3_rd", 32'h008, 0, 4'h0, 32'hAAAA_AAAA, lat, mvm);
      w0 = mem_writes;
      do_req("t3_wr", 32'h008, 32'h1122_3344, 4'b0011, 32'h0, lat, mvm);
      check("t3_wstrb_m", {28'b0, last_wstrb}, 32'h3);
      check("t3_memwr", 32'(mem_writes - w0), 32'd1);
      do_req("t3_rd2", 32'h008, 0, 4'h0, 32'hAAAA_3344, lat, mvm);
      check("t3_rd2_hit", 32'(mvm), 32'd0);
      check("t3_hits", hit_count, 32'd4);
      check("t3_misses", miss_count, 32'd6);

      // Uncached window
      w0 = mem_writes;
      do_req("t4_wr", 32'h1000_0000, 32'h41, 4'b0001, 32'h0, lat, mvm);
      check("t4_addr_m", last_addr, 32'h1000_0000);
      check("t4_memwr", 32'(mem_writes - w0), 32'd1);
      r0 = mem_reads;
      do_req("t4_rd1", 32'h1000_0000, 0, 4'h0, 32'h41, lat, mvm);
      do_req("t4_rd2", 32'h1000_0000, 0, 4'h0, 32'h41, lat, mvm);
      check("t4_memrd", 32'(mem_reads - r0), 32'd2);
      check("t4_hits", hit_count, 32'd4);
      check("t4_misses", miss_count, 32'd6);

      // Flush in IDLE
      for (int i = 0; i < 4; i++)
         do_req("t5_fill", 32'h010 + 4*i, 0, 4'h0, 32'h5000_0000 + i, lat, mvm);
      check("t5_fill_misses", miss_count, 32'd10);
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      r0 = mem_reads;
      for (int i = 0; i < 4; i++)
         do_req("t5_reread", 32'h010 + 4*i, 0, 4'h0, 32'h5000_0000 + i, lat, mvm);
      check("t5_memrd", 32'(mem_reads - r0), 32'd4);
      check("t5_misses", miss_count, 32'd14);
      check("t5_hits_kept", hit_count, 32'd4);

      // Flush raised during FILL, held until IDLE
      flush_on_fill = 1'b1;
      do_req("t5_ffill", 32'h020, 0, 4'h0, 32'h5000_0004, lat, mvm);
      flush_on_fill = 1'b0;
      check("t5_flush_seen", {31'b0, flush}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      r0 = mem_reads;
      do_req("t5_after", 32'h020, 0, 4'h0, 32'h5000_0004, lat, mvm);
      check("t5_after_memrd", 32'(mem_reads - r0), 32'd1);
      check("t5_after_misses", miss_count, 32'd16);

      // Reset while FILL waits on memory
      mem_hold = 1'b1;
      @(negedge clk);
      mem_valid = 1'b1; mem_addr = 32'h024; mem_wstrb = 4'h0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (mem_valid_m) break;
      end
      check("t6_fill_pending", {31'b0, mem_valid_m}, 32'd1);
      @(negedge clk);
      reset = 1'b1; mem_valid = 1'b0;
      #1;
      check("t6_valid_m_drop", {31'b0, mem_valid_m}, 32'd0);
      check("t6_hits0", hit_count, 32'd0);
      check("t6_misses0", miss_count, 32'd0);
      @(negedge clk);
      reset = 1'b0; mem_hold = 1'b0;
      r0 = mem_reads;
      do_req("t6_rd1", 32'h104, 0, 4'h0, 32'hB0B0_0104, lat, mvm);
      check("t6_memrd", 32'(mem_reads - r0), 32'd1);
      check("t6_misses", miss_count, 32'd1);
      do_req("t6_rd2", 32'h104, 0, 4'h0, 32'hB0B0_0104, lat, mvm);
      check("t6_hits", hit_count, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
